present_crypt_iter: RTL and testbench

//  Iterative, clocked PRESENT block-cipher engine: one round per cycle, shared round datapath.

---
 rtl/present_crypt_iter_pkg.sv | 54 +++++
 rtl/present_crypt_iter_if.sv | 24 ++
 rtl/present_crypt_iter_key_step.sv | 33 +++
 rtl/present_crypt_iter.sv | 119 +++++++++++
 tb/tb_present_crypt_iter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/present_crypt_iter_pkg.sv
// Shared PRESENT definitions: S-box tables, bit permutation, legal key widths and FSM encoding.
package present_crypt_iter_pkg;

    localparam int unsigned KEY_W_80  = 80;
    localparam int unsigned KEY_W_128 = 128;

    // Nibble i of each table holds S[i] / S^-1[i].
    localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRun  = 3'd1;
    localparam logic [2:0] StKeyx = 3'd2;
    localparam logic [2:0] StDec  = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
        return INV_SBOX_TBL[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 16; i++) y[4*i +: 4] = inv_sbox4(x[4*i +: 4]);
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[6'((16 * i) % 63)] = x[i];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) y[i] = x[6'((16 * i) % 63)];
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_crypt_iter_if.sv
// Request/response handshake bundle between the block buffer, the engine and the output FIFO.
interface present_crypt_iter_if #(
    parameter int unsigned KEY_W = 80
);
    logic             in_valid;
    logic             in_ready;
    logic             in_dec;
    logic [KEY_W-1:0] in_key;
    logic [63:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             busy;

    modport master (
        output in_valid, in_dec, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_dec, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/present_crypt_iter_key_step.sv
// One PRESENT key-schedule step, forward (dir_i=0) or its exact inverse (dir_i=1).
module present_crypt_iter_key_step
    import present_crypt_iter_pkg::*;
#(
    parameter int unsigned KEY_W = 80
) (
    input  logic [KEY_W-1:0] key_i,
    input  logic [4:0]       cnt_i,
    input  logic             dir_i,
    output logic [KEY_W-1:0] key_o
);

    localparam int unsigned CNT_LSB = (KEY_W == KEY_W_128) ? 62 : 15;

    logic [KEY_W-1:0] fwd;
    logic [KEY_W-1:0] inv;

    always_comb begin
        fwd = {key_i[KEY_W-62:0], key_i[KEY_W-1 -: 61]};
        fwd[KEY_W-1 -: 4] = sbox4(fwd[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) fwd[KEY_W-5 -: 4] = sbox4(fwd[KEY_W-5 -: 4]);
        fwd[CNT_LSB +: 5] = fwd[CNT_LSB +: 5] ^ cnt_i;
    end

    always_comb begin
        inv = key_i;
        inv[CNT_LSB +: 5] = inv[CNT_LSB +: 5] ^ cnt_i;
        inv[KEY_W-1 -: 4] = inv_sbox4(inv[KEY_W-1 -: 4]);
        if (KEY_W == KEY_W_128) inv[KEY_W-5 -: 4] = inv_sbox4(inv[KEY_W-5 -: 4]);
        key_o = dir_i ? {inv[60:0], inv[KEY_W-1:61]} : fwd;
    end

endmodule

// File: rtl/present_crypt_iter.sv
// Iterative PRESENT encrypt/decrypt engine: one round per clock through a shared datapath.
module present_crypt_iter
    import present_crypt_iter_pkg::*;
#(
    parameter int unsigned KEY_W  = 80,
    parameter int unsigned ROUNDS = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    present_crypt_iter_if.slave  bus
);

    if (!(KEY_W == KEY_W_80 || KEY_W == KEY_W_128)) begin : g_bad_key_w
        $error("KEY_W must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("ROUNDS must be in 1..31");
    end

    localparam logic [4:0] LAST_CNT = 5'(ROUNDS);

    logic [2:0]       state_q, state_d;
    logic [63:0]      st_q, st_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [63:0]      out_data_q, out_data_d;

    logic [KEY_W-1:0] key_nxt;
    logic [63:0]      key_top_nxt;
    logic [63:0]      round_enc;
    logic [63:0]      round_dec;

    present_crypt_iter_key_step #(
        .KEY_W (KEY_W)
    ) u_key_step (
        .key_i (key_q),
        .cnt_i (cnt_q),
        .dir_i (state_q == StDec),
        .key_o (key_nxt)
    );

    assign key_top_nxt = key_nxt[KEY_W-1 -: 64];
    assign round_enc   = p_layer(s_layer(st_q ^ key_q[KEY_W-1 -: 64]));
    assign round_dec   = inv_s_layer(inv_p_layer(st_q)) ^ key_top_nxt;

    always_comb begin
        state_d    = state_q;
        st_d       = st_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    st_d    = bus.in_data;
                    key_d   = bus.in_key;
                    cnt_d   = 5'd1;
                    state_d = bus.in_dec ? StKeyx : StRun;
                end
            end
            StRun: begin
                st_d  = round_enc;
                key_d = key_nxt;
                if (cnt_q == LAST_CNT) begin
                    out_data_d = round_enc ^ key_top_nxt;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StKeyx: begin
                // Roll the schedule forward to the final round key before peeling rounds off.
                key_d = key_nxt;
                if (cnt_q == LAST_CNT) begin
                    st_d    = st_q ^ key_top_nxt;
                    state_d = StDec;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDec: begin
                key_d = key_nxt;
                st_d  = round_dec;
                if (cnt_q == 5'd1) begin
                    out_data_d = round_dec;
                    state_d    = StDone;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            st_q       <= '0;
            key_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            st_q       <= st_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_present_crypt_iter.sv
// Directed bench for present_crypt_iter: 80-bit, 128-bit and single-round instances.
module tb_present_crypt_iter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   sel;
    logic         req_valid;
    logic         req_dec;
    logic [127:0] req_key;
    logic [63:0]  req_data;
    logic         rsp_ready;

    logic         o_valid;
    logic         o_in_ready;
    logic         o_busy;
    logic [63:0]  o_data;

    int n_checks;
    int n_fail;

    present_crypt_iter_if #(.KEY_W(80))  if80 ();
    present_crypt_iter_if #(.KEY_W(128)) if128 ();
    present_crypt_iter_if #(.KEY_W(80))  if1 ();

    present_crypt_iter #(.KEY_W(80), .ROUNDS(31)) u_dut80 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if80)
    );
    present_crypt_iter #(.KEY_W(128), .ROUNDS(31)) u_dut128 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if128)
    );
    present_crypt_iter #(.KEY_W(80), .ROUNDS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    assign if80.in_valid   = req_valid && (sel == 2'd0);
    assign if80.in_dec     = req_dec;
    assign if80.in_key     = req_key[79:0];
    assign if80.in_data    = req_data;
    assign if80.out_ready  = rsp_ready && (sel == 2'd0);
    assign if128.in_valid  = req_valid && (sel == 2'd1);
    assign if128.in_dec    = req_dec;
    assign if128.in_key    = req_key;
    assign if128.in_data   = req_data;
    assign if128.out_ready = rsp_ready && (sel == 2'd1);
    assign if1.in_valid    = req_valid && (sel == 2'd2);
    assign if1.in_dec      = req_dec;
    assign if1.in_key      = req_key[79:0];
    assign if1.in_data     = req_data;
    assign if1.out_ready   = rsp_ready && (sel == 2'd2);

    always_comb begin
        o_valid    = if80.out_valid;
        o_in_ready = if80.in_ready;
        o_busy     = if80.busy;
        o_data     = if80.out_data;
        if (sel == 2'd1) begin
            o_valid    = if128.out_valid;
            o_in_ready = if128.in_ready;
            o_busy     = if128.busy;
            o_data     = if128.out_data;
        end else if (sel == 2'd2) begin
            o_valid    = if1.out_valid;
            o_in_ready = if1.in_ready;
            o_busy     = if1.busy;
            o_data     = if1.out_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Caller sits just after a rising edge; returns just after the edge that raised out_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("out_valid_timeout", {127'd0, o_valid}, 128'd1);
    endtask

    task automatic take_result(output logic [63:0] res);
        res = o_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic issue(input logic dec, input logic [127:0] key, input logic [63:0] data);
        req_dec   = dec;
        req_key   = key;
        req_data  = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_block(input logic dec, input logic [127:0] key, input logic [63:0] data,
                             output logic [63:0] res, output int lat);
        issue(dec, key, data);
        wait_valid(lat);
        take_result(res);
    endtask

    localparam logic [127:0] KEY_F80 = {48'd0, {80{1'b1}}};

    logic [63:0]  res;
    logic [63:0]  ct;
    logic [127:0] rkey;
    logic [63:0]  rpt;
    int           lat;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sel       = 2'd0;
        req_valid = 1'b0;
        req_dec   = 1'b0;
        req_key   = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("rst_in_ready", {127'd0, o_in_ready}, 128'd1);
        check_eq("rst_out_valid", {127'd0, o_valid}, 128'd0);
        check_eq("rst_busy", {127'd0, o_busy}, 128'd0);
        check_eq("rst_out_data", {64'd0, o_data}, 128'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 80-bit known-answer vectors
        run_block(1'b0, '0, 64'h0, res, lat);
        check_eq("enc80_k0", {64'd0, res}, {64'd0, 64'h5579C1387B228445});
        check_eq("enc80_lat", lat, 128'd31);
        run_block(1'b0, KEY_F80, {64{1'b1}}, res, lat);
        check_eq("enc80_kf", {64'd0, res}, {64'd0, 64'h3333DCD3213210D2});
        check_eq("enc80_kf_lat", lat, 128'd31);
        run_block(1'b1, KEY_F80, 64'h3333DCD3213210D2, res, lat);
        check_eq("dec80_kf", {64'd0, res}, {64'd0, 64'hFFFFFFFFFFFFFFFF});
        check_eq("dec80_lat", lat, 128'd62);

        // 128-bit
        sel = 2'd1;
        run_block(1'b0, '0, 64'h0, res, lat);
        check_eq("enc128_k0", {64'd0, res}, {64'd0, 64'h96DB702A2E6900AF});
        check_eq("enc128_lat", lat, 128'd31);
        run_block(1'b1, '0, 64'h96DB702A2E6900AF, res, lat);
        check_eq("dec128_k0", {64'd0, res}, 128'd0);
        check_eq("dec128_lat", lat, 128'd62);

        // Backpressure with a second request already waiting
        sel = 2'd0;
        issue(1'b0, '0, 64'h0);
        req_key   = KEY_F80;
        req_data  = 64'h0;
        req_valid = 1'b1;
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_data", {64'd0, o_data}, {64'd0, 64'h5579C1387B228445});
            check_eq("bp_in_ready", {127'd0, o_in_ready}, 128'd0);
            @(posedge clk);
            #1;
        end
        check_eq("bp_valid_held", {127'd0, o_valid}, 128'd1);
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_ready_same_cycle", {127'd0, o_in_ready}, 128'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("bp_ready_next", {127'd0, o_in_ready}, 128'd1);
        check_eq("bp_valid_drop", {127'd0, o_valid}, 128'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("bp_accept_busy", {127'd0, o_busy}, 128'd1);
        wait_valid(lat);
        take_result(res);
        check_eq("bp_second", {64'd0, res}, {64'd0, 64'hE72C46C0F5945049});
        check_eq("bp_second_lat", lat, 128'd31);

        // Asynchronous reset in the middle of a block
        issue(1'b0, '0, 64'h0);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", {127'd0, o_in_ready}, 128'd1);
        check_eq("mid_rst_out_valid", {127'd0, o_valid}, 128'd0);
        check_eq("mid_rst_busy", {127'd0, o_busy}, 128'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_block(1'b0, KEY_F80, 64'h0, res, lat);
        check_eq("post_rst_enc", {64'd0, res}, {64'd0, 64'hE72C46C0F5945049});

        // Single-round instance
        sel = 2'd2;
        run_block(1'b0, '0, 64'h0, res, lat);
        check_eq("r1_enc_k0", {64'd0, res}, {64'd0, 64'h3FFFFFFF00000000});
        check_eq("r1_enc_lat", lat, 128'd1);
        run_block(1'b1, '0, 64'h3FFFFFFF00000000, res, lat);
        check_eq("r1_dec_k0", {64'd0, res}, 128'd0);
        check_eq("r1_dec_lat", lat, 128'd2);
        for (int i = 0; i < 1000; i++) begin
            rkey = {48'd0, 16'($urandom), $urandom, $urandom};
            rpt  = {$urandom, $urandom};
            run_block(1'b0, rkey, rpt, ct, lat);
            run_block(1'b1, rkey, ct, res, lat);
            check_eq("r1_roundtrip", {64'd0, res}, {64'd0, rpt});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
